// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencer for IF/ID, ID/EX and PC control, with a
// RUN/WFI/TRAP/RET FSM that handles WFI, interrupt entry and MRET.
module pipe_hazard_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       im_stall,
   input  logic       dm_stall,
   input  logic [4:0] ID_rs1,
   input  logic [4:0] ID_rs2,
   input  logic [4:0] EX_rd,
   input  logic       EX_memread,
   input  logic       EX_branch_taken,
   input  logic       EX_mret,
   input  logic       EX_wfi,
   input  logic       irq_pending,
   output logic       pc_write,
   output logic [1:0] pc_sel,
   output logic       IFID_write,
   output logic       IFID_flush,
   output logic       IDEX_flush,
   output logic       CSR_stall,
   output logic       CSR_interrupt,
   output logic       CSR_ret
);
   typedef enum logic [1:0] {RUN, WFI, TRAP, RET} state_t;
   state_t state_q, state_d;
   logic   blank_q, blank_d;
   logic   mem_stall, load_use;
   always_comb begin
      mem_stall     = im_stall | dm_stall;
      load_use      = EX_memread && (EX_rd != 5'd0) && (EX_rd == ID_rs1 || EX_rd == ID_rs2);
      state_d       = state_q;
      blank_d       = blank_q;
      pc_write      = 1'b0;
      pc_sel        = 2'd0;
      IFID_write    = 1'b0;
      IFID_flush    = 1'b0;
      IDEX_flush    = 1'b0;
      CSR_stall     = 1'b0;
      CSR_interrupt = 1'b0;
      CSR_ret       = 1'b0;
      if (reset) begin
         state_d = RUN;
         blank_d = 1'b0;
      end else if (mem_stall) begin
         CSR_stall = (state_q == WFI);
      end else begin
         // blank only survives the single unstalled cycle following TRAP
         blank_d = (state_q == TRAP);
         case (state_q)
            RUN: begin
               if (irq_pending && !blank_q) begin
                  state_d    = TRAP;
                  IFID_flush = 1'b1;
                  IDEX_flush = 1'b1;
               end else if (EX_mret) begin
                  state_d    = RET;
                  IFID_flush = 1'b1;
                  IDEX_flush = 1'b1;
               end else if (EX_branch_taken) begin
                  pc_sel     = 2'd1;
                  pc_write   = 1'b1;
                  IFID_write = 1'b1;
                  IFID_flush = 1'b1;
                  IDEX_flush = 1'b1;
               end else if (EX_wfi) begin
                  state_d    = WFI;
                  IDEX_flush = 1'b1;
               end else if (load_use) begin
                  IDEX_flush = 1'b1;
               end else begin
                  pc_write   = 1'b1;
                  IFID_write = 1'b1;
               end
            end
            WFI: begin
               CSR_stall  = 1'b1;
               IDEX_flush = 1'b1;
               state_d    = irq_pending ? TRAP : WFI;
            end
            TRAP: begin
               CSR_interrupt = 1'b1;
               pc_sel        = 2'd2;
               pc_write      = 1'b1;
               IFID_write    = 1'b1;
               IFID_flush    = 1'b1;
               IDEX_flush    = 1'b1;
               state_d       = RUN;
            end
            default: begin
               CSR_ret    = 1'b1;
               pc_sel     = 2'd3;
               pc_write   = 1'b1;
               IFID_write = 1'b1;
               IFID_flush = 1'b1;
               IDEX_flush = 1'b1;
               state_d    = RUN;
            end
         endcase
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         blank_q <= 1'b0;
      end else begin
         state_q <= state_d;
         blank_q <= blank_d;
      end
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the five-stage core. It drives the write-enable and flush controls of the IF/ID and ID/EX pipeline registers and the PC write and source select. It resolves load-use hazards, taken branches and memory stalls. A small FSM sequences WFI, interrupt entry and MRET with the CSR unit. It sits between the hazard inputs from ID/EX/MEM and the CSR-facing control pins of the IF/ID register and the PC mux.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces FSM to RUN and clears the blank bit.
- im_stall  in  1  instruction memory not ready.
- dm_stall  in  1  data memory not ready.
- ID_rs1, ID_rs2  in  5 each  source registers of the instruction in ID.
- EX_rd  in  5  destination register of the instruction in EX.
- EX_memread  in  1  instruction in EX is a load.
- EX_branch_taken  in  1  branch/jump resolved taken in EX.
- EX_mret  in  1  MRET in EX.
- EX_wfi  in  1  WFI in EX.
- irq_pending  in  1  level request from the CSR unit (already enable-masked).
- pc_write  out  1  PC register load enable.
- pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = mtvec, 3 = mepc.
- IFID_write  out  1  IF/ID load enable.
- IFID_flush  out  1  zero IF/ID contents.
- IDEX_flush  out  1  insert a bubble into ID/EX.
- CSR_stall  out  1  core is sleeping in WFI.
- CSR_interrupt  out  1  single-cycle pulse that takes the trap: save mepc and update mstatus.
- CSR_ret  out  1  single-cycle pulse that performs MRET: restore mstatus.

## Operation
- The FSM has four states: RUN, WFI, TRAP, RET. Outputs are combinational from the state, the blank bit and the inputs.
- While reset is high, every output is 0.
- mem_stall = im_stall | dm_stall. It has the highest priority in every state. While it is high:
  - pc_write, IFID_write, all flushes and both CSR pulses are 0.
  - The state holds.
  - In WFI, CSR_stall stays 1.
- RUN, no mem_stall. Priority is highest first:
  1. irq_pending & ~blank: go to TRAP. Outputs are pc_write = 0, IFID_write = 0, IFID_flush = 1, IDEX_flush = 1.
  2. EX_mret: go to RET, with the same freeze and flush outputs as case 1.
  3. EX_branch_taken: pc_sel = 1, pc_write = 1, IFID_write = 1, IFID_flush = 1, IDEX_flush = 1.
  4. EX_wfi: go to WFI. Outputs are pc_write = 0, IFID_write = 0, IDEX_flush = 1.
  5. Load-use: EX_memread & EX_rd != 0 & (EX_rd == ID_rs1 | EX_rd == ID_rs2). Outputs are pc_write = 0, IFID_write = 0, IDEX_flush = 1, IFID_flush = 0.
  6. Otherwise: pc_sel = 0, pc_write = 1, IFID_write = 1, no flush.
- WFI:
  - CSR_stall = 1, pc_write = 0, IFID_write = 0, IDEX_flush = 1.
  - When irq_pending is high, go to TRAP.
  - Branches, loads and MRET are ignored in this state.
- TRAP, no mem_stall:
  - CSR_interrupt = 1, pc_sel = 2, pc_write = 1, IFID_write = 1, IFID_flush = 1, IDEX_flush = 1.
  - Next state is RUN, and the blank bit is set.
- RET, no mem_stall:
  - CSR_ret = 1, pc_sel = 3, pc_write = 1, IFID_write = 1, IFID_flush = 1, IDEX_flush = 1.
  - Next state is RUN.
- Blank bit:
  - Set on exit from TRAP.
  - Cleared on the next non-stalled cycle.
  - While set, it masks irq_pending, which covers the one-cycle CSR update lag so the same interrupt is not re-entered.
- pc_sel is 0 whenever pc_write is 0.

## Timing
- Load-use costs exactly 1 bubble.
- A taken branch costs 2 squashed instructions: IF/ID flushed and ID/EX flushed in the same cycle.
- Interrupt from RUN:
  - Cycle n: irq_pending sampled high, FSM moves to TRAP.
  - Cycle n+1: CSR_interrupt and pc_sel = 2.
  - Cycle n+2: fetch from mtvec.
- Interrupt from WFI: the transition to TRAP happens in the same cycle irq_pending is first seen, with latency otherwise as above.
- MRET: CSR_ret is asserted 1 cycle after EX_mret is sampled.
- Each CSR pulse lasts exactly 1 cycle. If mem_stall holds TRAP or RET, the pulse is delayed until the first non-stalled cycle in that state, never repeated.
- Reset asserted mid-TRAP or mid-RET: the pulse is not emitted, the state becomes RUN immediately, and outputs are 0 until reset deasserts.
- First cycle after reset deassertion: the FSM is in RUN with normal decode.

## Test plan
- Load-use: EX_memread = 1, EX_rd = 5, ID_rs2 = 5 for 1 cycle -> pc_write = 0, IFID_write = 0, IDEX_flush = 1 for exactly 1 cycle. Repeating with EX_rd = 0 -> no stall.
- Branch during dm_stall: EX_branch_taken = 1 with dm_stall = 1 for 3 cycles -> all controls 0 for those 3 cycles. On the 4th cycle: pc_sel = 1, both flushes = 1.
- Interrupt versus branch in the same cycle: irq_pending = 1 and EX_branch_taken = 1 -> next cycle TRAP with CSR_interrupt = 1 and pc_sel = 2. Then with irq_pending held 1 for 2 more cycles -> no second CSR_interrupt.
- WFI wake: EX_wfi = 1, then 10 idle cycles -> CSR_stall = 1 throughout. Then irq_pending = 1 -> CSR_interrupt pulses 1 cycle later and CSR_stall drops.
- MRET with im_stall: EX_mret = 1, then im_stall = 1 for 2 cycles -> CSR_ret = 0 during the stall, then exactly one CSR_ret pulse with pc_sel = 3.
- Reset in TRAP: assert reset asynchronously while in TRAP -> all outputs 0 immediately, no CSR_interrupt pulse. After release -> normal RUN behaviour with pc_write = 1.
